// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: shared ALU opcodes, source selects and register constants.
package alu_operand_stage_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int OPCODE_LENGTH = 4;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SRA = 4'b0111
  } alu_op_t;
  typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO, SRC_A_RSVD} src_a_sel_t;
  typedef enum logic {SRC_B_RS2, SRC_B_IMM} src_b_sel_t;
  // one bit per opcode: set for SLL, SRL, SRA
  localparam logic [(1 << OPCODE_LENGTH)-1:0] SHIFT_OPS = 16'b0000_0000_1011_0000;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
  function automatic logic is_shift(input logic [OPCODE_LENGTH-1:0] op);
    return SHIFT_OPS[op];
  endfunction
endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: decode-side bundle and execute-side handshake of the operand stage.
interface alu_operand_stage_if #(
  parameter int DW = 32,
  parameter int OL = 4,
  parameter int RW = 5
);
  logic          id_valid;
  logic          id_ready;
  logic [DW-1:0] id_rs1_val;
  logic [DW-1:0] id_rs2_val;
  logic [DW-1:0] id_imm;
  logic [DW-1:0] id_pc;
  logic [RW-1:0] id_rs1_addr;
  logic [RW-1:0] id_rs2_addr;
  logic [RW-1:0] id_rd_addr;
  logic [1:0]    id_src_a_sel;
  logic          id_src_b_sel;
  logic [OL-1:0] id_operation;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          ex_ready;
  logic          ex_valid;
  logic [DW-1:0] ex_src_a;
  logic [DW-1:0] ex_src_b;
  logic [OL-1:0] ex_operation;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_rd_addr;
  logic          ex_reg_write;
  logic          ex_mem_read;
  modport master (
    output id_valid, id_rs1_val, id_rs2_val, id_imm, id_pc, id_rs1_addr, id_rs2_addr,
           id_rd_addr, id_src_a_sel, id_src_b_sel, id_operation, id_reg_write, id_mem_read,
           ex_ready,
    input  id_ready, ex_valid, ex_src_a, ex_src_b, ex_operation, ex_store_data, ex_rd_addr,
           ex_reg_write, ex_mem_read
  );
  modport slave (
    input  id_valid, id_rs1_val, id_rs2_val, id_imm, id_pc, id_rs1_addr, id_rs2_addr,
           id_rd_addr, id_src_a_sel, id_src_b_sel, id_operation, id_reg_write, id_mem_read,
           ex_ready,
    output id_ready, ex_valid, ex_src_a, ex_src_b, ex_operation, ex_store_data, ex_rd_addr,
           ex_reg_write, ex_mem_read
  );
endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// fwd_mux: priority forwarding select for one source operand (EX, then MEM, then WB, then regfile).
module fwd_mux
  import alu_operand_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] rs,
  input  logic [DW-1:0] rf_val,
  input  logic          ex_en,
  input  logic [RW-1:0] ex_rd,
  input  logic [DW-1:0] ex_val,
  input  logic          mem_en,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_val,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_val,
  output logic [DW-1:0] val
);
  assign val = rs == ZERO_REG        ? '0      :
               ex_en  && ex_rd  == rs ? ex_val  :
               mem_en && mem_rd == rs ? mem_val :
               wb_en  && wb_rd  == rs ? wb_val  : rf_val;
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register that forwards, selects and masks ALU operands,
// stalling decode on load-use hazards and on execute back-pressure.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH = alu_operand_stage_pkg::DATA_WIDTH,
  parameter int OPCODE_LENGTH = alu_operand_stage_pkg::OPCODE_LENGTH,
  parameter int REG_ADDR_W = alu_operand_stage_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_write,
  input  logic                  mem_fwd_ok,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_reg_write,
  input  logic [DATA_WIDTH-1:0] wb_result,
  alu_operand_stage_if.slave    bus
);
  localparam int SW = $clog2(DATA_WIDTH);
  logic                  advance, hazard, haz1, haz2, use1, use2, ex_fwd_en;
  logic [DATA_WIDTH-1:0] rs1_f, rs2_f, op_a, op_b, src_b_next;
  function automatic logic raw_hazard(input logic [REG_ADDR_W-1:0] rs);
    return rs != ZERO_REG &&
           ((bus.ex_valid && bus.ex_mem_read && bus.ex_rd_addr == rs) ||
            (mem_reg_write && !mem_fwd_ok && mem_rd_addr == rs));
  endfunction
  assign ex_fwd_en = bus.ex_valid && bus.ex_reg_write && !bus.ex_mem_read;
  fwd_mux #(.DW(DATA_WIDTH), .RW(REG_ADDR_W)) u_fwd_rs1 (
    .rs(bus.id_rs1_addr), .rf_val(bus.id_rs1_val),
    .ex_en(ex_fwd_en), .ex_rd(bus.ex_rd_addr), .ex_val(alu_result),
    .mem_en(mem_reg_write && mem_fwd_ok), .mem_rd(mem_rd_addr), .mem_val(mem_result),
    .wb_en(wb_reg_write), .wb_rd(wb_rd_addr), .wb_val(wb_result), .val(rs1_f)
  );
  fwd_mux #(.DW(DATA_WIDTH), .RW(REG_ADDR_W)) u_fwd_rs2 (
    .rs(bus.id_rs2_addr), .rf_val(bus.id_rs2_val),
    .ex_en(ex_fwd_en), .ex_rd(bus.ex_rd_addr), .ex_val(alu_result),
    .mem_en(mem_reg_write && mem_fwd_ok), .mem_rd(mem_rd_addr), .mem_val(mem_result),
    .wb_en(wb_reg_write), .wb_rd(wb_rd_addr), .wb_val(wb_result), .val(rs2_f)
  );
  // a load-use conflict only matters for an operand the instruction actually reads
  assign use1 = src_a_sel_t'(bus.id_src_a_sel) == SRC_A_RS1;
  assign use2 = src_b_sel_t'(bus.id_src_b_sel) == SRC_B_RS2;
  assign haz1 = raw_hazard(bus.id_rs1_addr);
  assign haz2 = raw_hazard(bus.id_rs2_addr);
  assign advance = !bus.ex_valid || bus.ex_ready;
  assign hazard = bus.id_valid && ((use1 && haz1) || (use2 && haz2));
  assign bus.id_ready = advance && !hazard && !flush;
  assign op_a = src_a_sel_t'(bus.id_src_a_sel) == SRC_A_RS1 ? rs1_f :
                src_a_sel_t'(bus.id_src_a_sel) == SRC_A_PC  ? bus.id_pc : '0;
  assign op_b = src_b_sel_t'(bus.id_src_b_sel) == SRC_B_IMM ? bus.id_imm : rs2_f;
  assign src_b_next = is_shift(bus.id_operation) ? {{(DATA_WIDTH-SW){1'b0}}, op_b[SW-1:0]} : op_b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid      <= 1'b0;
      bus.ex_src_a      <= '0;
      bus.ex_src_b      <= '0;
      bus.ex_operation  <= '0;
      bus.ex_store_data <= '0;
      bus.ex_rd_addr    <= '0;
      bus.ex_reg_write  <= 1'b0;
      bus.ex_mem_read   <= 1'b0;
    end else if (flush) begin
      bus.ex_valid <= 1'b0;
    end else if (advance) begin
      if (hazard || !bus.id_valid) begin
        bus.ex_valid     <= 1'b0;
        bus.ex_reg_write <= 1'b0;
        bus.ex_mem_read  <= 1'b0;
      end else begin
        bus.ex_valid      <= 1'b1;
        bus.ex_src_a      <= op_a;
        bus.ex_src_b      <= src_b_next;
        bus.ex_operation  <= bus.id_operation;
        bus.ex_store_data <= rs2_f;
        bus.ex_rd_addr    <= bus.id_rd_addr;
        bus.ex_reg_write  <= bus.id_reg_write;
        bus.ex_mem_read   <= bus.id_mem_read;
      end
    end
  end
endmodule
